// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with enable, synchronous load (invalid digits
// forced to 0 and flagged), and a registered one-cycle wrap pulse for cascading.
module bcd_updown_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  wrap,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                wrap_q, wrap_d;
    logic                load_err_q, load_err_d;

    // all9[k] / all0[k]: every digit below k is 9 / 0 (the ripple enable chain)
    logic [DIGITS:0]     all9, all0;

    always_comb begin
        all9[0] = 1'b1;
        all0[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            all9[k+1] = all9[k] & (bcd_q[4*k +: 4] == 4'd9);
            all0[k+1] = all0[k] & (bcd_q[4*k +: 4] == 4'd0);
        end
    end

    always_comb begin
        bcd_d      = bcd_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (load_val[4*k +: 4] > 4'd9) begin
                    bcd_d[4*k +: 4] = 4'd0;
                    load_err_d      = 1'b1;
                end else begin
                    bcd_d[4*k +: 4] = load_val[4*k +: 4];
                end
            end
        end else if (en) begin
            if (up_dn) begin
                wrap_d = all9[DIGITS];
                for (int k = 0; k < DIGITS; k++) begin
                    if (all9[k]) begin
                        bcd_d[4*k +: 4] = (bcd_q[4*k +: 4] == 4'd9) ? 4'd0
                                          : bcd_q[4*k +: 4] + 4'd1;
                    end
                end
            end else begin
                wrap_d = all0[DIGITS];
                for (int k = 0; k < DIGITS; k++) begin
                    if (all0[k]) begin
                        bcd_d[4*k +: 4] = (bcd_q[4*k +: 4] == 4'd0) ? 4'd9
                                          : bcd_q[4*k +: 4] - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q      <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            bcd_q      <= bcd_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bcd      = bcd_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: a 4-digit instance driven by directed and random
// steps against an integer-valued model, plus a free-running 1-digit instance.
module tb_bcd_updown_counter;

    localparam int D    = 4;
    localparam int MAXV = 10000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0, up_dn = 1'b1, load = 1'b0;
    logic [4*D-1:0] load_val = '0;
    logic [4*D-1:0] bcd;
    logic          wrap, load_err;

    logic          en1 = 1'b0;
    logic [3:0]    bcd1;
    logic          wrap1, load_err1;

    int checks = 0;
    int passed = 0;

    // model state: plain integers
    int m_val = 0, m1_val = 0;
    bit m_wrap = 0, m_err = 0, m1_wrap = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(D)) dut4 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .bcd(bcd), .wrap(wrap), .load_err(load_err)
    );

    bcd_updown_counter #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .up_dn(1'b1), .load(1'b0),
        .load_val(4'd0), .bcd(bcd1), .wrap(wrap1), .load_err(load_err1)
    );

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Apply current inputs for one edge, advance the model, compare everything.
    task automatic step();
        bit r, l, e, u, e1;
        logic [4*D-1:0] lv;
        int p, dg;
        r = rst; l = load; e = en; u = up_dn; e1 = en1; lv = load_val;
        @(posedge clk);
        #1;
        if (r) begin
            m_val = 0; m_wrap = 0; m_err = 0;
        end else if (l) begin
            m_val = 0; m_wrap = 0; m_err = 0; p = 1;
            for (int k = 0; k < D; k++) begin
                dg = int'(lv[4*k +: 4]);
                if (dg > 9) begin
                    m_err = 1;
                    dg = 0;
                end
                m_val += dg * p;
                p = p * 10;
            end
        end else if (e) begin
            m_err = 0;
            if (u) begin
                m_wrap = (m_val == MAXV - 1);
                m_val  = (m_val + 1) % MAXV;
            end else begin
                m_wrap = (m_val == 0);
                m_val  = (m_val + MAXV - 1) % MAXV;
            end
        end else begin
            m_wrap = 0; m_err = 0;
        end
        if (r) begin
            m1_val = 0; m1_wrap = 0;
        end else if (e1) begin
            m1_wrap = (m1_val == 9);
            m1_val  = (m1_val + 1) % 10;
        end else begin
            m1_wrap = 0;
        end
        check("bcd", 32'(bcd), 32'(to_bcd(m_val)));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("load_err", 32'(load_err), 32'(m_err));
        check("bcd1", 32'(bcd1), 32'(m1_val));
        check("wrap1", 32'(wrap1), 32'(m1_wrap));
        check("load_err1", 32'(load_err1), 32'd0);
    endtask

    task automatic do_load(input logic [4*D-1:0] v);
        load = 1'b1; load_val = v; en = 1'b0;
        step();
        load = 1'b0;
    endtask

    initial begin
        // reset
        @(negedge clk);
        rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 16'h1234;
        step();
        check("reset_bcd", 32'(bcd), 32'h0);
        rst = 1'b0; load = 1'b0;

        // count up 10, then to 9999, then wrap
        en = 1'b1; up_dn = 1'b1; en1 = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("count10", 32'(bcd), 32'h0010);
        for (int i = 10; i < 9999; i++) step();
        check("at_9999", 32'(bcd), 32'h9999);
        step();
        check("upwrap_bcd", 32'(bcd), 32'h0000);
        check("upwrap_pulse", 32'(wrap), 32'd1);
        step();
        check("wrap_one_cycle", 32'(wrap), 32'd0);

        // down-count borrow and down-wrap
        do_load(16'h1000);
        en = 1'b1; up_dn = 1'b0;
        step();
        check("borrow", 32'(bcd), 32'h0999);
        do_load(16'h0000);
        en = 1'b1; up_dn = 1'b0;
        step();
        check("downwrap_bcd", 32'(bcd), 32'h9999);
        check("downwrap_pulse", 32'(wrap), 32'd1);

        // load validity
        do_load(16'h12A4);
        check("load_bad_bcd", 32'(bcd), 32'h1204);
        check("load_bad_err", 32'(load_err), 32'd1);
        step();
        check("load_err_one_cycle", 32'(load_err), 32'd0);
        do_load(16'h5678);
        check("load_good_bcd", 32'(bcd), 32'h5678);

        // priority: load beats en at 9999
        do_load(16'h9999);
        load = 1'b1; en = 1'b1; up_dn = 1'b1; load_val = 16'h1234;
        step();
        check("load_over_en", 32'(bcd), 32'h1234);
        check("load_no_wrap", 32'(wrap), 32'd0);
        load = 1'b0;

        // hold and direction flip
        do_load(16'h0042);
        en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("hold", 32'(bcd), 32'h0042);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            up_dn = (i % 2 == 0);
            step();
            check("flip", 32'(bcd), (i % 2 == 0) ? 32'h0043 : 32'h0042);
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            load  = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 3) != 0);
            up_dn = $urandom_range(0, 1);
            en1   = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       load_val = 16'h9999;
                1:       load_val = 16'h0000;
                2:       load_val = 16'($urandom_range(0, 65535));
                default: load_val = to_bcd($urandom_range(0, 9999));
            endcase
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
